// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: step/sequence controls in, register state and handshake out.
// master = controlling FSM or bench, slave = the register.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] qout;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;
    logic             carry;

    modport master (
        output en, mode, din, sin_l, sin_r, start, amt,
        input  qout, sout_msb, sout_lsb, busy, done, carry
    );

    modport slave (
        input  en, mode, din, sin_l, sin_r, start, amt,
        output qout, sout_msb, sout_lsb, busy, done, carry
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/clear/shift/rotate plus an N-step shift sequencer.
// Define UREG_CARRY_EN to add a registered carry holding the last bit shifted or rotated out.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input logic             clk,
    input logic             rst,
    univ_shift_reg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [2:0]       op_r, op_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic             step_en;
    logic [2:0]       step_mode;
    logic             busy_r, done_r;

    function automatic logic is_shift(input logic [2:0] m);
        return (m >= M_SHL) && (m <= M_ASR);
    endfunction

    function automatic logic [WIDTH-1:0] step_fn(input logic [2:0]       m,
                                                 input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic             sl,
                                                 input logic             sr);
        logic [WIDTH-1:0] r;
        case (m)
            M_HOLD:  r = v;
            M_LOAD:  r = d;
            M_SHL:   r = {v[WIDTH-2:0], sl};
            M_SHR:   r = {sr, v[WIDTH-1:1]};
            M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   r = {v[0], v[WIDTH-1:1]};
            M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // A start with a non-shift mode swallows the whole cycle, including en.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_r;
        cnt_nxt   = cnt;
        step_en   = 1'b0;
        step_mode = M_HOLD;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (is_shift(bus.mode)) begin
                        op_nxt    = bus.mode;
                        cnt_nxt   = bus.amt;
                        state_nxt = (bus.amt == '0) ? DONE : RUN;
                    end
                end else if (bus.en) begin
                    step_en   = 1'b1;
                    step_mode = bus.mode;
                end
            end
            RUN: begin
                step_en   = 1'b1;
                step_mode = op_r;
                cnt_nxt   = cnt - 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        q_nxt = step_en ? step_fn(step_mode, q, bus.din, bus.sin_l, bus.sin_r) : q;
    end

    // busy/done come straight from flops, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            op_r   <= M_HOLD;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            op_r   <= op_nxt;
            cnt    <= cnt_nxt;
            busy_r <= (state_nxt != IDLE);
            done_r <= (state_nxt == DONE);
        end
    end

`ifdef UREG_CARRY_EN
    logic carry_r, carry_nxt;

    always_comb begin
        carry_nxt = carry_r;
        if (step_en) begin
            case (step_mode)
                M_SHL, M_ROL:        carry_nxt = q[WIDTH-1];
                M_SHR, M_ROR, M_ASR: carry_nxt = q[0];
                M_LOAD, M_CLR:       carry_nxt = 1'b0;
                default:             carry_nxt = carry_r;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_r <= 1'b0;
        end else begin
            carry_r <= carry_nxt;
        end
    end

    assign bus.carry = carry_r;
`else
    assign bus.carry = 1'b0;
`endif

    assign bus.qout     = q;
    assign bus.sout_msb = q[WIDTH-1];
    assign bus.sout_lsb = q[0];
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: vector table, hand-written sequences and random
// traffic, all compared against an arithmetic reference model of the register.
module tb_univ_shift_reg;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int MOD = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic clk;
    logic rst;
    int   total;
    int   bad;

    univ_shift_reg_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    univ_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register value, carry, steps still owed and a pending done pulse.
    int mQ;
    int mCarry;
    int mRemain;
    int mOp;
    int mDone;

    typedef struct {
        logic [2:0]   mode;
        logic [W-1:0] pre;
        logic [W-1:0] din;
        logic         sl;
        logic         sr;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic bit isShiftMode(input int m);
        return (m >= 2) && (m <= 6);
    endfunction

    task automatic modelReset();
        mQ = 0; mCarry = 0; mRemain = 0; mOp = 0; mDone = 0;
    endtask

    task automatic modelApply(input int m, input int din, input int sl, input int sr);
        int old;
        old = mQ;
        case (m)
            0: mQ = old;
            1: begin mQ = din; mCarry = 0; end
            2: begin mQ = (old * 2 + sl) % MOD;          mCarry = old / HALF; end
            3: begin mQ = old / 2 + sr * HALF;           mCarry = old % 2;    end
            4: begin mQ = (old * 2) % MOD + old / HALF;  mCarry = old / HALF; end
            5: begin mQ = old / 2 + (old % 2) * HALF;    mCarry = old % 2;    end
            6: begin mQ = old / 2 + (old / HALF) * HALF; mCarry = old % 2;    end
            default: begin mQ = 0; mCarry = 0; end
        endcase
    endtask

    task automatic modelEdge();
        if (mRemain > 0) begin
            modelApply(mOp, int'(bus.din), int'(bus.sin_l), int'(bus.sin_r));
            mRemain = mRemain - 1;
            mDone = (mRemain == 0) ? 1 : 0;
        end else if (mDone != 0) begin
            mDone = 0;
        end else if (bus.start) begin
            if (isShiftMode(int'(bus.mode))) begin
                mOp = int'(bus.mode);
                mRemain = int'(bus.amt);
                mDone = (mRemain == 0) ? 1 : 0;
            end
        end else if (bus.en) begin
            modelApply(int'(bus.mode), int'(bus.din), int'(bus.sin_l), int'(bus.sin_r));
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        total = total + 1;
        if (got != want) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input string name);
        int wantCarry;
`ifdef UREG_CARRY_EN
        wantCarry = mCarry;
`else
        wantCarry = 0;
`endif
        checkValue({name, ".qout"}, int'(bus.qout), mQ);
        checkValue({name, ".busy"}, int'(bus.busy), ((mRemain > 0) || (mDone != 0)) ? 1 : 0);
        checkValue({name, ".done"}, int'(bus.done), (mDone != 0 && mRemain == 0) ? 1 : 0);
        checkValue({name, ".carry"}, int'(bus.carry), wantCarry);
        checkValue({name, ".sout_msb"}, int'(bus.sout_msb), mQ / HALF);
        checkValue({name, ".sout_lsb"}, int'(bus.sout_lsb), mQ % 2);
    endtask

    task automatic applyStimulus(input logic e, input logic [2:0] m, input logic [W-1:0] d,
                                 input logic sl, input logic sr, input logic st,
                                 input logic [AW-1:0] a);
        bus.en = e; bus.mode = m; bus.din = d;
        bus.sin_l = sl; bus.sin_r = sr; bus.start = st; bus.amt = a;
    endtask

    task automatic stepCycle(input string name);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(name);
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic loadValue(input logic [W-1:0] v);
        applyStimulus(1'b1, 3'b001, v, 1'b0, 1'b0, 1'b0, '0);
        stepCycle("load");
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic midReset(input string name);
        #2 rst = 1'b1;
        #1 modelReset();
        checkOutput(name);
        #1 rst = 1'b0;
    endtask

    initial begin
        int busyCycles;
        int doneCount;

        total = 0;
        bad = 0;
        rst = 1'b1;
        idleInputs();
        modelReset();
        #12;
        checkOutput("reset");
        rst = 1'b0;

        vecs[0] = '{mode: 3'b001, pre: 8'h00, din: 8'hA5, sl: 1'b0, sr: 1'b0, exp: 8'hA5};
        vecs[1] = '{mode: 3'b111, pre: 8'hA5, din: 8'h00, sl: 1'b0, sr: 1'b0, exp: 8'h00};
        vecs[2] = '{mode: 3'b010, pre: 8'h81, din: 8'h00, sl: 1'b1, sr: 1'b0, exp: 8'h03};
        vecs[3] = '{mode: 3'b011, pre: 8'h81, din: 8'h00, sl: 1'b1, sr: 1'b0, exp: 8'h40};
        vecs[4] = '{mode: 3'b110, pre: 8'h81, din: 8'h00, sl: 1'b0, sr: 1'b0, exp: 8'hC0};
        vecs[5] = '{mode: 3'b101, pre: 8'h81, din: 8'h00, sl: 1'b0, sr: 1'b0, exp: 8'hC0};
        vecs[6] = '{mode: 3'b100, pre: 8'h81, din: 8'h00, sl: 1'b0, sr: 1'b0, exp: 8'h03};
        vecs[7] = '{mode: 3'b000, pre: 8'h3C, din: 8'hFF, sl: 1'b1, sr: 1'b1, exp: 8'h3C};
        vecs[8] = '{mode: 3'b011, pre: 8'h81, din: 8'h00, sl: 1'b0, sr: 1'b1, exp: 8'hC0};

        for (int i = 0; i < 9; i++) begin
            loadValue(vecs[i].pre);
            applyStimulus(1'b1, vecs[i].mode, vecs[i].din, vecs[i].sl, vecs[i].sr, 1'b0, '0);
            stepCycle("vec");
            checkValue($sformatf("vec%0d.exp", i), int'(bus.qout), int'(vecs[i].exp));
        end

        loadValue(8'hA5);
        idleInputs();
        midReset("midcycle_reset");
        checkValue("midcycle_reset.zero", int'(bus.qout), 0);

`ifdef UREG_CARRY_EN
        loadValue(8'h81);
        applyStimulus(1'b1, 3'b010, '0, 1'b0, 1'b0, 1'b0, '0);
        stepCycle("carry_shl");
        checkValue("carry_shl.one", int'(bus.carry), 1);
        loadValue(8'h02);
        checkValue("carry_load.zero", int'(bus.carry), 0);
        applyStimulus(1'b1, 3'b011, '0, 1'b0, 1'b0, 1'b0, '0);
        stepCycle("carry_shr");
        checkValue("carry_shr.zero", int'(bus.carry), 0);
`endif

        // Sequenced ROL of 96 by 3: four busy cycles, one done pulse, ends at B4.
        loadValue(8'h96);
        applyStimulus(1'b0, 3'b100, '0, 1'b0, 1'b0, 1'b1, 3'd3);
        stepCycle("rol3_start");
        idleInputs();
        busyCycles = (bus.busy === 1'b1) ? 1 : 0;
        doneCount = (bus.done === 1'b1) ? 1 : 0;
        for (int c = 0; c < 20 && bus.busy === 1'b1; c++) begin
            stepCycle("rol3_run");
            if (bus.busy === 1'b1) busyCycles++;
            if (bus.done === 1'b1) doneCount++;
        end
        checkValue("rol3.busy_cycles", busyCycles, 4);
        checkValue("rol3.done_pulses", doneCount, 1);
        checkValue("rol3.final", int'(bus.qout), 8'hB4);

        // amt=0: done pulse on the next cycle, value untouched.
        loadValue(8'h5A);
        applyStimulus(1'b0, 3'b010, '0, 1'b1, 1'b0, 1'b1, 3'd0);
        stepCycle("amt0_start");
        checkValue("amt0.done", int'(bus.done), 1);
        checkValue("amt0.q", int'(bus.qout), 8'h5A);
        idleInputs();
        stepCycle("amt0_idle");
        checkValue("amt0.idle", int'(bus.busy), 0);

        // amt=7 exceeds no limit: ROR 01 seven times lands on 02.
        loadValue(8'h01);
        applyStimulus(1'b0, 3'b101, '0, 1'b0, 1'b0, 1'b1, 3'd7);
        stepCycle("ror7_start");
        idleInputs();
        for (int c = 0; c < 8; c++) stepCycle("ror7_run");
        checkValue("ror7.final", int'(bus.qout), 8'h02);
        checkValue("ror7.idle", int'(bus.busy), 0);

        // en/start while busy (including the done cycle) must be ignored.
        loadValue(8'hC3);
        applyStimulus(1'b0, 3'b101, '0, 1'b0, 1'b0, 1'b1, 3'd4);
        stepCycle("busy_ign_start");
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 3'b010, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd2);
            stepCycle("busy_ign_run");
        end
        checkValue("busy_ign.final", int'(bus.qout), 8'h3C);
        idleInputs();
        stepCycle("busy_ign_idle");

        // start with load mode does nothing, and masks en.
        loadValue(8'h11);
        applyStimulus(1'b1, 3'b001, 8'hEE, 1'b0, 1'b0, 1'b1, 3'd2);
        stepCycle("start_load");
        checkValue("start_load.q", int'(bus.qout), 8'h11);
        checkValue("start_load.busy", int'(bus.busy), 0);

        // Reset in the second RUN cycle aborts with no done pulse.
        loadValue(8'hFF);
        applyStimulus(1'b0, 3'b010, '0, 1'b1, 1'b0, 1'b1, 3'd5);
        stepCycle("abort_start");
        idleInputs();
        stepCycle("abort_run1");
        midReset("abort_reset");
        doneCount = 0;
        for (int c = 0; c < 6; c++) begin
            stepCycle("abort_after");
            if (bus.done === 1'b1) doneCount++;
        end
        checkValue("abort.no_done", doneCount, 0);
        checkValue("abort.busy", int'(bus.busy), 0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0), AW'($urandom));
            stepCycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
